// File: rtl/ram_256_sync_pkg.sv
// Shared constants, request struct and address alignment helper for the 256-byte data RAM.
package ram_pkg;
  localparam int RAM_DEPTH  = 256;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;
  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic                  en;
    logic                  rw;
    logic [RAM_ADDR_W-1:0] addr;
    logic [1:0]            size;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

  // Natural alignment: low address bits are dropped so an access never wraps past the top.
  function automatic logic [RAM_ADDR_W-1:0] align_addr(input logic [RAM_ADDR_W-1:0] addr,
                                                       input logic [1:0] size);
    case (size)
      SIZE_HALF: align_addr = {addr[RAM_ADDR_W-1:1], 1'b0};
      SIZE_WORD: align_addr = {addr[RAM_ADDR_W-1:2], 2'b00};
      default:   align_addr = addr;
    endcase
  endfunction
endpackage

// File: rtl/ram_byte_lane.sv
// Per-byte write enables, big-endian write steering and zero-extended read assembly.
// Lane i always maps to byte address base+i.
module ram_byte_lane
  import ram_pkg::*;
#(
  parameter int NUM_L = NUM_LANES,
  parameter int VEC_W = LANE_W
) (
  input  logic [1:0]                  size,
  input  logic [NUM_L*VEC_W-1:0]      wdata,
  input  logic [NUM_L-1:0][VEC_W-1:0] rd_bytes,
  output logic [NUM_L-1:0]            we,
  output logic [NUM_L-1:0][VEC_W-1:0] wr_bytes,
  output logic [NUM_L*VEC_W-1:0]      rdata
);
  always_comb begin
    we       = '0;
    wr_bytes = '0;
    for (int i = 0; i < NUM_L; i++) begin
      case (size)
        SIZE_BYTE: begin
          we[i]       = (i == 0);
          wr_bytes[i] = wdata[VEC_W-1:0];
        end
        SIZE_HALF: begin
          we[i]       = (i < 2);
          wr_bytes[i] = (i % 2 == 1) ? wdata[VEC_W-1:0] : wdata[2*VEC_W-1:VEC_W];
        end
        SIZE_WORD: begin
          we[i]       = 1'b1;
          wr_bytes[i] = wdata[VEC_W*(NUM_L-1-i) +: VEC_W];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (size)
      SIZE_BYTE: rdata[VEC_W-1:0]   = rd_bytes[0];
      SIZE_HALF: rdata[2*VEC_W-1:0] = {rd_bytes[0], rd_bytes[1]};
      SIZE_WORD:
        for (int i = 0; i < NUM_L; i++) rdata[VEC_W*(NUM_L-1-i) +: VEC_W] = rd_bytes[i];
      default: ;
    endcase
  end
endmodule

// File: rtl/ram_256_sync.sv
// 256-byte big-endian synchronous data RAM with byte/half/word access and 1-cycle MFC.
// Define RAM_MEM_RESET_EN to clear the storage array on reset; otherwise it has no reset.
module ram_256_sync
  import ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [RAM_DATA_W-1:0] DataOut,
  output logic                  MFC,
  input  logic                  Enable,
  input  logic                  ReadWrite,
  input  logic [RAM_ADDR_W-1:0] Address,
  input  logic [RAM_DATA_W-1:0] DataIn,
  input  logic [1:0]            DataSize
);
  logic [LANE_W-1:0] mem_q [RAM_DEPTH];

  ram_req_t                        req;
  logic [RAM_ADDR_W-1:0]           base;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_bytes;
  logic [NUM_LANES-1:0][LANE_W-1:0] wr_bytes;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0]            we_d;
  logic [RAM_DATA_W-1:0]           rdata;
  logic [RAM_DATA_W-1:0]           data_out_d, data_out_q;
  logic                            mfc_d, mfc_q;

  assign req  = '{en: Enable, rw: ReadWrite, addr: Address, size: DataSize, wdata: DataIn};
  assign base = align_addr(req.addr, req.size);

  always_comb begin
    rd_bytes = '0;
    for (int i = 0; i < NUM_LANES; i++) rd_bytes[i] = mem_q[base + RAM_ADDR_W'(i)];
  end

  ram_byte_lane #(.NUM_L(NUM_LANES), .VEC_W(LANE_W)) u_lane (
    .size     (req.size),
    .wdata    (req.wdata),
    .rd_bytes (rd_bytes),
    .we       (lane_we),
    .wr_bytes (wr_bytes),
    .rdata    (rdata)
  );

  always_comb begin
    we_d       = (req.en && req.rw == RW_WRITE) ? lane_we : '0;
    data_out_d = (req.en && req.rw == RW_READ) ? rdata : data_out_q;
    mfc_d      = req.en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      mfc_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      mfc_q      <= mfc_d;
    end
  end

`ifdef RAM_MEM_RESET_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < RAM_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (we_d[i]) mem_q[base + RAM_ADDR_W'(i)] <= wr_bytes[i];
    end
  end
`else
  // No reset on the array so synthesis can map it to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (we_d[i]) mem_q[base + RAM_ADDR_W'(i)] <= wr_bytes[i];
  end
`endif

  assign DataOut = data_out_q;
  assign MFC     = mfc_q;
endmodule

// File: tb/tb_ram_256_sync.sv
// Directed plus random bench for ram_256_sync against a byte-array reference model.
module tb_ram_256_sync;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Enable;
  logic        ReadWrite;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [1:0]  DataSize;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl [256];
  logic [31:0] exp_dout;
  logic        exp_mfc;

  ram_256_sync dut (
    .clk(clk), .reset_n(reset_n), .DataOut(DataOut), .MFC(MFC), .Enable(Enable),
    .ReadWrite(ReadWrite), .Address(Address), .DataIn(DataIn), .DataSize(DataSize)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input int a, input int sz);
    int b;
    case (sz)
      0: return {24'h0, mdl[a]};
      1: begin b = a - (a % 2); return {16'h0, mdl[b], mdl[b+1]}; end
      2: begin b = a - (a % 4); return {mdl[b], mdl[b+1], mdl[b+2], mdl[b+3]}; end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input int a, input int sz, input logic [31:0] d);
    int b;
    case (sz)
      0: mdl[a] = d[7:0];
      1: begin b = a - (a % 2); mdl[b] = d[15:8]; mdl[b+1] = d[7:0]; end
      2: begin
        b = a - (a % 4);
        mdl[b] = d[31:24]; mdl[b+1] = d[23:16]; mdl[b+2] = d[15:8]; mdl[b+3] = d[7:0];
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    exp_dout = 32'h0;
    exp_mfc  = 1'b0;
`ifdef RAM_MEM_RESET_EN
    for (int k = 0; k < 256; k++) mdl[k] = 8'h00;
`endif
  endtask

  task automatic check(input string tag);
    total++;
    assert (MFC === exp_mfc) else begin
      bad++;
      $error("FAIL %s mfc: got %b want %b", tag, MFC, exp_mfc);
    end
    total++;
    assert (DataOut === exp_dout) else begin
      bad++;
      $error("FAIL %s dout: got %h want %h", tag, DataOut, exp_dout);
    end
  endtask

  task automatic step(input logic en, input logic rw, input int a, input int sz,
                      input logic [31:0] d, input string tag);
    @(negedge clk);
    Enable = en; ReadWrite = rw; Address = 8'(a); DataSize = 2'(sz); DataIn = d;
    @(posedge clk);
    exp_mfc = en;
    if (en) begin
      if (rw) exp_dout = model_read(a, sz);
      else    model_write(a, sz, d);
    end
    #1 check(tag);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    Enable = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1 check(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; Enable = 1'b0; ReadWrite = 1'b1; Address = '0; DataIn = '0; DataSize = '0;
    for (int k = 0; k < 256; k++) mdl[k] = 8'hxx;
    model_reset();
    #12 check("reset");
    @(negedge clk) reset_n = 1'b1;

    step(1, 0, 8'h00, 2, 32'h11223344, "prime0");
    reset_pulse("reset2");

    step(0, 0, 8'h00, 2, 32'hFFFFFFFF, "t1_dis_wr");
    step(1, 1, 8'h00, 0, 32'h0,        "t1_rd");

    step(1, 0, 8'h00, 0, 32'hFFFFFF0B, "t2_wr");
    step(1, 1, 8'h00, 0, 32'h0,        "t2_rd");

    step(1, 0, 8'hF0, 1, 32'hABCDEF1A, "t3_wr");
    step(1, 1, 8'hF0, 1, 32'h0,        "t3_rdh");
    step(1, 1, 8'hF0, 0, 32'h0,        "t3_rdb0");
    step(1, 1, 8'hF1, 0, 32'h0,        "t3_rdb1");

    step(1, 0, 8'hFC, 2, 32'hABCDEF1C, "t4_wr");
    step(1, 1, 8'hFC, 2, 32'h0,        "t4_rdfc");
    step(1, 1, 8'hFE, 2, 32'h0,        "t4_rdfe");
    step(1, 1, 8'hFF, 0, 32'h0,        "t4_rdff");

    step(1, 0, 8'h10, 2, 32'hCAFEF00D, "t5_prime");
    step(1, 0, 8'h10, 3, 32'h12345678, "t5_rsvd_wr");
    step(1, 1, 8'h10, 2, 32'h0,        "t5_rd");
    step(1, 1, 8'h10, 3, 32'h0,        "t5_rsvd_rd");
    step(1, 1, 8'h10, 3, 32'h0,        "t5_rsvd_rd2");

    for (int w = 0; w < 64; w++) step(1, 0, w * 4, 2, $urandom, "rnd_init");
    for (int n = 0; n < 400; n++)
      step(($urandom % 8) != 0, $urandom % 2, $urandom % 256, $urandom % 4, $urandom, "rnd");

    // Held write interrupted by reset between edges.
    @(negedge clk);
    Enable = 1'b1; ReadWrite = 1'b0; Address = 8'h40; DataSize = 2'b10; DataIn = 32'h5A5A1234;
    @(posedge clk);
    exp_mfc = 1'b1;
    model_write(8'h40, 2, 32'h5A5A1234);
    #1 check("t6_held");
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("t6_async");
    @(negedge clk);
    Enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 8'h40, 2, 32'h0, "t6_rd40");
    step(1, 1, 8'h00, 0, 32'h0, "t6_rd00");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
